// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 constants, padder state/source types and helpers
package sha256_pkg;

    localparam logic [31:0] PAD_WORD = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN,
        OFFER,
        DONE
    } pad_state_t;

    typedef enum logic [1:0] {
        SRC_MSG,
        SRC_PAD,
        SRC_LEN,
        SRC_ZERO
    } word_src_t;

    // Padded length always leaves room for the 0x80 word plus two length words.
    function automatic int num_blocks(input int n);
        return (n + 2) / 16 + 1;
    endfunction

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - reads a fixed-length message from memory and emits SHA-256 padded 512-bit blocks
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  message_addr,
    output logic         mem_clk,
    output logic         mem_we,
    output logic [15:0]  mem_addr,
    input  logic [31:0]  mem_read_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last,
    output logic [7:0]   blk_idx,
    output logic         busy,
    output logic         done
);

    localparam int          NB       = num_blocks(NUM_OF_WORDS);
    localparam logic [7:0]  LAST_IDX = 8'(NB - 1);
    localparam logic [11:0] MSG_LEN  = 12'(NUM_OF_WORDS);
    localparam logic [31:0] LEN_LO   = 32'(NUM_OF_WORDS * 32);

    pad_state_t  state;
    logic [3:0]  p;
    logic [15:0] base;
    logic [31:0] buffer [16];

    // Write-back stage: memory data for a position arrives one cycle after its address.
    logic        wr_en;
    logic [3:0]  wr_pos;
    word_src_t   wr_src;

    logic [11:0] g;
    word_src_t   src_sel;
    logic [31:0] wr_word;

    assign mem_clk = clk;
    assign mem_we  = 1'b0;
    assign g       = {blk_idx, p};

    always_comb begin
        src_sel = SRC_ZERO;
        if (g < MSG_LEN)
            src_sel = SRC_MSG;
        else if (g == MSG_LEN)
            src_sel = SRC_PAD;
        else if (blk_idx == LAST_IDX && p == 4'd15)
            src_sel = SRC_LEN;
    end

    always_comb begin
        wr_word = 32'h0;
        case (wr_src)
            SRC_MSG:  wr_word = mem_read_data;
            SRC_PAD:  wr_word = PAD_WORD;
            SRC_LEN:  wr_word = LEN_LO;
            default:  wr_word = 32'h0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_blk_word
            assign blk_data[511 - 32*gi -: 32] = buffer[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            p         <= 4'd0;
            base      <= 16'h0;
            mem_addr  <= 16'h0;
            blk_idx   <= 8'd0;
            blk_last  <= 1'b0;
            blk_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_en     <= 1'b0;
            wr_pos    <= 4'd0;
            wr_src    <= SRC_ZERO;
            for (int i = 0; i < 16; i++)
                buffer[i] <= 32'h0;
        end else begin
            done  <= 1'b0;
            wr_en <= 1'b0;
            if (wr_en)
                buffer[wr_pos] <= wr_word;

            case (state)
                IDLE: begin
                    if (start) begin
                        base     <= message_addr;
                        mem_addr <= message_addr;
                        blk_idx  <= 8'd0;
                        blk_last <= (LAST_IDX == 8'd0);
                        p        <= 4'd0;
                        busy     <= 1'b1;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    wr_en  <= 1'b1;
                    wr_pos <= p;
                    wr_src <= src_sel;
                    if (p == 4'd15) begin
                        state <= DRAIN;
                    end else begin
                        p        <= p + 4'd1;
                        mem_addr <= base + {4'd0, g + 12'd1};
                    end
                end
                DRAIN: begin
                    blk_valid <= 1'b1;
                    state     <= OFFER;
                end
                OFFER: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        if (blk_idx != LAST_IDX) begin
                            blk_idx  <= blk_idx + 8'd1;
                            blk_last <= (blk_idx + 8'd1 == LAST_IDX);
                            p        <= 4'd0;
                            mem_addr <= base + {4'd0, blk_idx + 8'd1, 4'd0};
                            state    <= FILL;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
